// File: rtl/div_result_collector.sv
// div_result_collector: drains byte-serial divider results (Q lo, Q hi, R lo, R hi) through the
// OutBuffFull/ReceiveData handshake and queues {quotient, remainder} in a first-word-fall-through FIFO.
module div_result_collector #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    OutBuffFull,
  input  logic [7:0]              DataOut,
  output logic                    ReceiveData,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [15:0]             res_quotient,
  output logic [15:0]             res_remainder,
  output logic [$clog2(DEPTH):0]  res_count,
  output logic                    frame_busy
);
  localparam int unsigned ptrWidth = $clog2(DEPTH);
  localparam int unsigned cntWidth = ptrWidth + 1;

  typedef enum logic [1:0] {Fetch = 2'd0, Ack = 2'd1, Gap = 2'd2} stateT;

  stateT                state, stateNext;
  logic [1:0]           byteIdx, byteIdxNext;
  logic [31:0]          frameReg;
  logic [31:0]          fifoMem [DEPTH];
  logic [ptrWidth-1:0]  wrPtr, rdPtr, rdPtrNext;
  logic [cntWidth-1:0]  countNext, remainAfterPop;
  logic                 pushC, popC;
  logic                 receiveDataNext, frameBusyNext, resValidNext;
  logic [31:0]          headNext;

  // Next state; a new frame only starts when the FIFO has a free entry, so the closing push always fits.
  always_comb begin
    stateNext = state;
    case (state)
      Fetch: if (OutBuffFull && (byteIdx != 2'd0 || res_count < cntWidth'(DEPTH))) stateNext = Ack;
      Ack:   stateNext = Gap;
      Gap:   stateNext = Fetch;
      default: stateNext = Fetch;
    endcase
  end

  // Next values for the frame counter, FIFO bookkeeping and registered outputs.
  always_comb begin
    byteIdxNext = byteIdx;
    pushC       = 1'b0;
    if (state == Gap) begin
      pushC       = (byteIdx == 2'd3);
      byteIdxNext = byteIdx + 2'd1;
    end
    popC           = res_valid & res_ready;
    rdPtrNext      = rdPtr + ptrWidth'(popC);
    remainAfterPop = res_count - cntWidth'(popC);
    countNext      = remainAfterPop + cntWidth'(pushC);
    resValidNext   = (countNext != '0);
    // Head bypasses storage when the pushed entry lands in an otherwise empty FIFO.
    headNext = {res_remainder, res_quotient};
    if (remainAfterPop == '0) begin
      if (pushC) headNext = frameReg;
    end else begin
      headNext = fifoMem[rdPtrNext];
    end
    receiveDataNext = (stateNext == Ack);
    frameBusyNext   = (byteIdxNext != 2'd0) || (stateNext != Fetch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= Fetch;
      byteIdx       <= 2'd0;
      frameReg      <= 32'd0;
      wrPtr         <= '0;
      rdPtr         <= '0;
      res_count     <= '0;
      res_valid     <= 1'b0;
      res_quotient  <= 16'd0;
      res_remainder <= 16'd0;
      ReceiveData   <= 1'b0;
      frame_busy    <= 1'b0;
    end else begin
      state   <= stateNext;
      byteIdx <= byteIdxNext;
      if (state == Ack) frameReg[{byteIdx, 3'b000} +: 8] <= DataOut;
      if (pushC) wrPtr <= wrPtr + ptrWidth'(1);
      rdPtr                         <= rdPtrNext;
      res_count                     <= countNext;
      res_valid                     <= resValidNext;
      {res_remainder, res_quotient} <= headNext;
      ReceiveData                   <= receiveDataNext;
      frame_busy                    <= frameBusyNext;
    end
  end

  always_ff @(posedge clk) begin
    if (pushC) fifoMem[wrPtr] <= frameReg;
  end

endmodule
